// File: rtl/clkdiv_ctrl.sv
// ============================================================================
// clkdiv_ctrl
// ----------------------------------------------------------------------------
// Programmable clock divider with a glitch-free divisor hand-over.
//
// The block divides clock_in by an active divisor D (>= 2). A period counter
// runs 0..D-1; clock_out is high for the first floor(D/2) counts of each
// period and low for the rest. The low phase is the longer one for odd D.
// A new divisor offered while dividing is parked in a pending register and
// only takes effect at the end of the current period. This keeps every output
// period whole, so the switch never produces a truncated period.
//
// Ports
//   clock_in     in   1      single clock, all logic on its rising edge
//   reset_n      in   1      synchronous active-low reset
//   enable       in   1      run request (level); a stop waits for period end
//   cfg_valid    in   1      a new divisor is offered
//   cfg_divisor  in   WIDTH  offered divisor value
//   cfg_ready    out  1      divisor can be accepted this cycle
//   cfg_err      out  1      one-cycle pulse after a divisor below 2 is offered
//   clock_out    out  1      divided clock (registered)
//   tick         out  1      pulse in the first cycle of each output period
//   running      out  1      high while dividing (RUN or PEND)
//
// Parameters
//   WIDTH            divisor / counter width in bits
//   DEFAULT_DIVISOR  active divisor loaded at reset
// ============================================================================
module clkdiv_ctrl #(
   parameter int WIDTH           = 28,
   parameter int DEFAULT_DIVISOR = 2
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_divisor,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clock_out,
   output logic             tick,
   output logic             running
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] C_ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] C_TWO     = WIDTH'(32'd2);
   localparam logic [WIDTH-1:0] C_DEF_DIV = WIDTH'(DEFAULT_DIVISOR);

   // Length of the high phase of a period: floor(D/2).
   function automatic logic [WIDTH-1:0] f_high_len(input logic [WIDTH-1:0] d);
      f_high_len = d >> 1;
   endfunction

   // Registered state
   state_t           r_state;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] r_cnt;
   logic             r_clk_out;
   logic             r_tick;
   logic             r_err;
   logic             r_running;

   // Next-state / decode wires
   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_div_nxt;
   logic [WIDTH-1:0] w_pend_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_hs;
   logic             w_accept;
   logic             w_reject;
   logic             w_period_end;
   logic             w_clk_out_nxt;
   logic             w_tick_nxt;
   logic             w_running_nxt;
   logic             w_active_nxt;

   // cfg_ready follows reset_n directly so that the very first cycle after
   // reset release can already complete a handshake.
   assign cfg_ready    = reset_n & (r_state != ST_PEND);
   assign w_hs         = cfg_valid & cfg_ready;
   assign w_accept     = w_hs & (cfg_divisor >= C_TWO);
   assign w_reject     = w_hs & (cfg_divisor <  C_TWO);
   // D is always >= 2, so D-1 never underflows.
   assign w_period_end = (r_state != ST_IDLE) && (r_cnt == (r_div - C_ONE));

   // Next-state logic: state, active/pending divisor and period counter.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_pend_nxt  = r_pend;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            // Stopped: an accepted divisor becomes active immediately.
            if (w_accept) begin
               w_div_nxt = cfg_divisor;
            end else begin
               w_div_nxt = r_div;
            end
            w_cnt_nxt = C_ZERO;
            if (enable) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_period_end) begin
               w_cnt_nxt = C_ZERO;
               if (!enable) begin
                  // Stopping: nothing left to wait for, so an offer made on
                  // this very cycle is applied straight away.
                  w_state_nxt = ST_IDLE;
                  if (w_accept) begin
                     w_div_nxt = cfg_divisor;
                  end else begin
                     w_div_nxt = r_div;
                  end
               end else if (w_accept) begin
                  // Offer on the period-end cycle waits for the next period end.
                  w_state_nxt = ST_PEND;
                  w_pend_nxt  = cfg_divisor;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
               if (w_accept) begin
                  w_state_nxt = ST_PEND;
                  w_pend_nxt  = cfg_divisor;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_PEND: begin
            if (w_period_end) begin
               // Hand-over happens exactly on the period boundary.
               w_div_nxt = r_pend;
               w_cnt_nxt = C_ZERO;
               if (enable) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_cnt_nxt   = r_cnt + C_ONE;
               w_state_nxt = ST_PEND;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = C_ZERO;
         end
      endcase
   end

   // Output decode from the next-cycle values, so clock_out/tick are
   // registered on the same edge as the counter and never lag it.
   always_comb begin
      w_active_nxt  = (w_state_nxt != ST_IDLE);
      w_running_nxt = w_active_nxt;
      if (w_active_nxt) begin
         w_clk_out_nxt = (w_cnt_nxt < f_high_len(w_div_nxt));
         w_tick_nxt    = (w_cnt_nxt == C_ZERO);
      end else begin
         w_clk_out_nxt = 1'b0;
         w_tick_nxt    = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_div     <= C_DEF_DIV;
         r_pend    <= C_ZERO;
         r_cnt     <= C_ZERO;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
         r_err     <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_pend    <= w_pend_nxt;
         r_cnt     <= w_cnt_nxt;
         r_clk_out <= w_clk_out_nxt;
         r_tick    <= w_tick_nxt;
         r_err     <= w_reject;
         r_running <= w_running_nxt;
      end
   end

   assign clock_out = r_clk_out;
   assign tick      = r_tick;
   assign cfg_err   = r_err;
   assign running   = r_running;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// ============================================================================
// tb_clkdiv_ctrl
// Scoreboard bench: the driver applies stimulus on the falling edge, advances
// a period-level reference model and queues the expected outputs; a separate
// monitor samples the DUT just after each rising edge and compares.
// ============================================================================
module tb_clkdiv_ctrl;

   localparam int W   = 8;
   localparam int DEF = 2;

   logic         clock_in    = 1'b0;
   logic         reset_n     = 1'b0;
   logic         enable      = 1'b0;
   logic         cfg_valid   = 1'b0;
   logic [W-1:0] cfg_divisor = '0;
   logic         cfg_ready;
   logic         cfg_err;
   logic         clock_out;
   logic         tick;
   logic         running;

   clkdiv_ctrl #(.WIDTH(W), .DEFAULT_DIVISOR(DEF)) dut (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .enable      (enable),
      .cfg_valid   (cfg_valid),
      .cfg_divisor (cfg_divisor),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .clock_out   (clock_out),
      .tick        (tick),
      .running     (running)
   );

   always #5 clock_in = ~clock_in;

   typedef struct packed {
      logic co;
      logic tk;
      logic rn;
      logic er;
      logic rd;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Reference model: running flag, divisor in use, position within period,
   // queued divisor (if any) and the error pulse.
   bit m_run;
   bit m_pend;
   bit m_err;
   int m_cnt;
   int m_d;
   int m_p;

   function automatic void model_step(input bit rn, input bit en, input bit v, input int d);
      bit rdy;
      bit acc;
      if (!rn) begin
         m_run  = 1'b0;
         m_pend = 1'b0;
         m_err  = 1'b0;
         m_cnt  = 0;
         m_d    = DEF;
         m_p    = 0;
      end else begin
         rdy   = !m_pend;
         acc   = v && rdy && (d >= 2);
         m_err = v && rdy && (d < 2);
         if (!m_run) begin
            if (acc) m_d = d;
            m_run = en;
            m_cnt = 0;
         end else begin
            m_cnt = (m_cnt + 1) % m_d;
            if (m_cnt != 0) begin
               if (acc) begin
                  m_p    = d;
                  m_pend = 1'b1;
               end
            end else if (m_pend) begin
               m_d    = m_p;
               m_pend = 1'b0;
               m_run  = en;
            end else if (!en) begin
               m_run = 1'b0;
               if (acc) m_d = d;
            end else if (acc) begin
               m_p    = d;
               m_pend = 1'b1;
            end
         end
      end
   endfunction

   task automatic drive(input bit rn, input bit en, input bit v, input int d);
      exp_t e;
      @(negedge clock_in);
      reset_n     = rn;
      enable      = en;
      cfg_valid   = v;
      cfg_divisor = d[W-1:0];
      model_step(rn, en, v, d);
      e.co = m_run && ((2 * m_cnt + 2) <= m_d);
      e.tk = m_run && (m_cnt == 0);
      e.rn = m_run;
      e.er = m_err;
      e.rd = rn && !m_pend;
      exp_q.push_back(e);
   endtask

   task automatic check1(input string nm, input logic act, input logic expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, expv);
      end
   endtask

   // Run (enable held) until the model is at the given counter value.
   task automatic run_to_cnt(input int c);
      int k;
      k = 0;
      while (!(m_run && m_cnt == c) && k < 600) begin
         drive(1'b1, 1'b1, 1'b0, 0);
         k++;
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock_in);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check1("clock_out", clock_out, e.co);
            check1("tick",      tick,      e.tk);
            check1("running",   running,   e.rn);
            check1("cfg_err",   cfg_err,   e.er);
            check1("cfg_ready", cfg_ready, e.rd);
         end
      end
   end

   // Stimulus
   initial begin
      int r;
      int d;
      model_step(1'b0, 1'b0, 1'b0, 0);

      // Reset state, then default D=2 run
      repeat (3) drive(1'b0, 1'b0, 1'b0, 0);
      repeat (8) drive(1'b1, 1'b1, 1'b0, 0);
      repeat (3) drive(1'b1, 1'b0, 1'b0, 0);

      // Odd divisor loaded in IDLE
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b1, 5);
      repeat (12) drive(1'b1, 1'b1, 1'b0, 0);

      // Glitch-free switch 4 -> 6 offered at counter 1
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b1, 4);
      drive(1'b1, 1'b1, 1'b0, 0);
      run_to_cnt(1);
      drive(1'b1, 1'b1, 1'b1, 6);
      drive(1'b1, 1'b1, 1'b1, 3);   // ignored: not ready while queued
      repeat (15) drive(1'b1, 1'b1, 1'b0, 0);

      // Rejections while running
      drive(1'b1, 1'b1, 1'b1, 1);
      drive(1'b1, 1'b1, 1'b0, 0);
      drive(1'b1, 1'b1, 1'b1, 0);
      repeat (8) drive(1'b1, 1'b1, 1'b0, 0);

      // Stop at counter 1 with D=4
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b1, 4);
      drive(1'b1, 1'b1, 1'b0, 0);
      run_to_cnt(1);
      repeat (5) drive(1'b1, 1'b0, 1'b0, 0);

      // Reset while a divisor is pending
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b1, 1'b0, 0);
      drive(1'b1, 1'b1, 1'b1, 8);
      drive(1'b0, 1'b1, 1'b0, 0);
      repeat (8) drive(1'b1, 1'b1, 1'b0, 0);

      // Handshake on a period-end cycle is deferred one period
      run_to_cnt(1);
      drive(1'b1, 1'b1, 1'b1, 3);
      repeat (8) drive(1'b1, 1'b1, 1'b0, 0);

      // Largest divisor for this width, one full period and a wrap
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b1, 255);
      repeat (260) drive(1'b1, 1'b1, 1'b0, 0);

      // Load and start on the same cycle
      drive(1'b0, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b1, 1'b1, 3);
      repeat (7) drive(1'b1, 1'b1, 1'b0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2)       d = r;
         else if (r == 2) d = $urandom_range(10, 40);
         else             d = $urandom_range(2, 9);
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 5) == 0), d);
      end

      repeat (2) @(posedge clock_in);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
